// File: rtl/genclk_ctrl.sv
// genclk_ctrl: sequences NCO -> 8:1 DDR serializer clock output path.
// Optional drain timeout: define GENCLK_CTRL_TIMEOUT_EN.
module genclk_ctrl #(
  parameter int BW         = 32,
  parameter int WARM_CYC   = 4,
  parameter int FLUSH_CYC  = 3,
  parameter int TIMEOUT_LG = 10
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic          i_req_en,
  input  logic [BW-1:0] i_req_incr,
  output logic [BW-1:0] o_incr,
  output logic          o_phase_clr,
  input  logic [7:0]    i_word,
  output logic [7:0]    o_word,
  output logic          o_ce,
  output logic          o_running,
  output logic          o_err
);

  localparam int CW = 8;

  typedef enum logic [2:0] {
    S_OFF,
    S_WARM,
    S_RUN,
    S_DRAIN,
    S_FLUSH
  } state_t;

  // counters are CW bits wide; catch configurations that cannot fit
  if (WARM_CYC < 1 || WARM_CYC > 256 ||
      FLUSH_CYC < 1 || FLUSH_CYC > 256 ||
      TIMEOUT_LG < 1 || BW < 1) begin : g_bad_param
    $error("genclk_ctrl: parameter out of range");
  end

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] incr_n;
  logic [7:0]    word_n;
  logic          ce_n;
  logic          clr_n;
  logic          acc;
  logic          run_req;

  // a zero increment can never toggle the pin, so it means stop
  assign run_req     = i_req_en && (i_req_incr != '0);
  assign o_req_ready = (state == S_OFF) || (state == S_RUN);
  assign acc         = i_req_valid && o_req_ready;
  assign o_running   = (state == S_RUN);

`ifdef GENCLK_CTRL_TIMEOUT_EN
  logic [TIMEOUT_LG-1:0] tcnt, tcnt_n;
  logic                  err_q, err_n;
  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  // next-state and next-output decode
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    incr_n  = o_incr;
    word_n  = '0;
    clr_n   = 1'b0;
    // CE follows the state one cycle late so it stays aligned with o_word
    ce_n    = (state != S_OFF);
`ifdef GENCLK_CTRL_TIMEOUT_EN
    tcnt_n  = tcnt;
    err_n   = err_q;
`endif
    unique case (state)
      S_OFF: begin
        if (acc && run_req) begin
          incr_n  = i_req_incr;
          clr_n   = 1'b1;
          cnt_n   = CW'(WARM_CYC - 1);
          state_n = S_WARM;
`ifdef GENCLK_CTRL_TIMEOUT_EN
          err_n   = 1'b0;
`endif
        end
      end
      S_WARM: begin
        if (cnt == '0) state_n = S_RUN;
        else            cnt_n   = cnt - 1'b1;
      end
      S_RUN: begin
        word_n = i_word;
        if (acc) begin
          if (run_req) begin
            incr_n = i_req_incr;
`ifdef GENCLK_CTRL_TIMEOUT_EN
            err_n  = 1'b0;
`endif
          end else begin
            state_n = S_DRAIN;
`ifdef GENCLK_CTRL_TIMEOUT_EN
            tcnt_n  = '0;
`endif
          end
        end
      end
      S_DRAIN: begin
        word_n = i_word;
        if (!i_word[0]) begin
          cnt_n   = CW'(FLUSH_CYC - 1);
          state_n = S_FLUSH;
        end
`ifdef GENCLK_CTRL_TIMEOUT_EN
        else if (tcnt == '1) begin
          word_n  = '0;
          err_n   = 1'b1;
          cnt_n   = CW'(FLUSH_CYC - 1);
          state_n = S_FLUSH;
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
`endif
      end
      S_FLUSH: begin
        if (cnt == '0) state_n = S_OFF;
        else            cnt_n   = cnt - 1'b1;
      end
      default: state_n = S_OFF;
    endcase
  end

  // state and registered outputs
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= S_OFF;
      cnt         <= '0;
      o_incr      <= '0;
      o_word      <= '0;
      o_ce        <= 1'b0;
      o_phase_clr <= 1'b0;
`ifdef GENCLK_CTRL_TIMEOUT_EN
      tcnt        <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      o_incr      <= incr_n;
      o_word      <= word_n;
      o_ce        <= ce_n;
      o_phase_clr <= clr_n;
`ifdef GENCLK_CTRL_TIMEOUT_EN
      tcnt        <= tcnt_n;
      err_q       <= err_n;
`endif
    end
  end

endmodule

// File: tb/tb_genclk_ctrl.sv
// tb_genclk_ctrl: directed bench for genclk_ctrl.
// Define GENCLK_CTRL_TIMEOUT_EN to also exercise the drain timeout.
module tb_genclk_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_en;
  logic [31:0] i_req_incr;
  logic [31:0] o_incr;
  logic        o_phase_clr;
  logic [7:0]  i_word;
  logic [7:0]  o_word;
  logic        o_ce;
  logic        o_running;
  logic        o_err;

  int checks = 0;
  int errors = 0;

  genclk_ctrl dut (
    .i_clk       (i_clk),
    .i_reset_n   (i_reset_n),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_en    (i_req_en),
    .i_req_incr  (i_req_incr),
    .o_incr      (o_incr),
    .o_phase_clr (o_phase_clr),
    .i_word      (i_word),
    .o_word      (o_word),
    .o_ce        (o_ce),
    .o_running   (o_running),
    .o_err       (o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ce, word, ready, running, clr in one call
  task automatic chk_st(input string tag, input logic ce,
                        input logic [7:0] w, input logic rdy,
                        input logic run, input logic clr);
    chk({tag, ".ce"},  32'(o_ce),        32'(ce));
    chk({tag, ".wd"},  32'(o_word),      32'(w));
    chk({tag, ".rdy"}, 32'(o_req_ready), 32'(rdy));
    chk({tag, ".run"}, 32'(o_running),   32'(run));
    chk({tag, ".clr"}, 32'(o_phase_clr), 32'(clr));
  endtask

  initial begin
    i_reset_n   = 1'b0;
    i_req_valid = 1'b0;
    i_req_en    = 1'b0;
    i_req_incr  = '0;
    i_word      = 8'h00;
    #3;
    chk_st("rst", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("rst.incr", o_incr, 32'h0);
    chk("rst.err", 32'(o_err), 32'h0);
    @(negedge i_clk);
    i_reset_n = 1'b1;

    // idle after reset
    i_word = 8'hA5;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_st("idle", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end

    // start: phase clear, 4 warm cycles of zero word
    i_req_valid = 1'b1;
    i_req_en    = 1'b1;
    i_req_incr  = 32'h4000_0000;
    i_word      = 8'hAA;
    tick();
    i_req_valid = 1'b0;
    chk_st("start", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("start.incr", o_incr, 32'h4000_0000);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_st("warm", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    end
    tick();
    chk_st("warm4", 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    i_word = 8'h0F;
    tick();
    chk_st("run0F", 1'b1, 8'h0F, 1'b1, 1'b1, 1'b0);
    i_word = 8'h3C;
    tick();
    chk_st("run3C", 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0);

    // retune in RUN: phase-continuous
    i_req_valid = 1'b1;
    i_req_en    = 1'b1;
    i_req_incr  = 32'h2000_0000;
    tick();
    i_req_valid = 1'b0;
    chk_st("retune", 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0);
    chk("retune.incr", o_incr, 32'h2000_0000);

    // stop: F1, F0 passed, 3 zero words with CE, then CE low
    i_word      = 8'hF1;
    i_req_valid = 1'b1;
    i_req_en    = 1'b0;
    tick();
    i_req_valid = 1'b0;
    chk_st("stopF1", 1'b1, 8'hF1, 1'b0, 1'b0, 1'b0);
    i_word = 8'hF0;
    tick();
    chk_st("stopF0", 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
    i_word = 8'hFF;
    tick();
    chk_st("flush1", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    chk_st("flush2", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    chk_st("flush3", 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    chk_st("off", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("off.incr", o_incr, 32'h2000_0000);

    // zero-incr run request in OFF is consumed
    i_req_valid = 1'b1;
    i_req_en    = 1'b1;
    i_req_incr  = 32'h0;
    tick();
    i_req_valid = 1'b0;
    chk_st("z_off", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    chk_st("z_off2", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("z_off.incr", o_incr, 32'h2000_0000);

    // restart, then zero-incr request in RUN drains
    i_req_valid = 1'b1;
    i_req_incr  = 32'h0000_1234;
    tick();
    i_req_valid = 1'b0;
    chk("re.clr", 32'(o_phase_clr), 32'h1);
    chk("re.incr", o_incr, 32'h0000_1234);
    repeat (4) tick();
    chk_st("re.run", 1'b1, 8'h00, 1'b1, 1'b1, 1'b0);
    i_word      = 8'hFF;
    i_req_valid = 1'b1;
    i_req_en    = 1'b1;
    i_req_incr  = 32'h0;
    tick();
    i_req_valid = 1'b0;
    chk_st("z_run", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk_st("drainFF", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    end
    i_word = 8'h02;
    tick();
    chk_st("drain02", 1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    i_word = 8'hFF;
    repeat (2) tick();
    chk_st("zflush", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    chk_st("zflush3", 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    chk_st("zoff", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("zoff.err", 32'(o_err), 32'h0);

`ifdef GENCLK_CTRL_TIMEOUT_EN
    // drain timeout after 1024 cycles of bit0 high
    i_req_valid = 1'b1;
    i_req_en    = 1'b1;
    i_req_incr  = 32'h1111_0000;
    tick();
    i_req_en    = 1'b0;
    repeat (4) tick();
    tick();
    i_req_valid = 1'b0;
    chk("to.drain", 32'(o_req_ready), 32'h0);
    repeat (1023) tick();
    chk_st("to.pre", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    chk("to.pre.err", 32'(o_err), 32'h0);
    tick();
    chk_st("to.hit", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("to.err", 32'(o_err), 32'h1);
    repeat (3) tick();
    chk_st("to.off", 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("to.err.off", 32'(o_err), 32'h1);
    i_req_valid = 1'b1;
    i_req_en    = 1'b1;
    i_req_incr  = 32'h0000_0100;
    tick();
    i_req_valid = 1'b0;
    chk("to.clr", 32'(o_err), 32'h0);
    repeat (4) tick();
`else
    // restart for the reset test
    i_req_valid = 1'b1;
    i_req_en    = 1'b1;
    i_req_incr  = 32'h0000_0100;
    tick();
    i_req_valid = 1'b0;
    repeat (4) tick();
`endif

    // asynchronous reset mid-RUN
    i_word = 8'h5A;
    tick();
    chk_st("pre_rst", 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0);
    @(negedge i_clk);
    i_reset_n = 1'b0;
    #1;
    chk_st("arst", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("arst.incr", o_incr, 32'h0);
    chk("arst.err", 32'(o_err), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
